// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the ALU sequencing controller: ALU op codes, command codes,
// FSM state encoding and the decoded ALU control bundle.
package alu_seq_ctrl_pkg;

    localparam logic [2:0] ALU_ROL = 3'd0;
    localparam logic [2:0] ALU_SLL = 3'd1;
    localparam logic [2:0] ALU_SRA = 3'd2;
    localparam logic [2:0] ALU_SRL = 3'd3;
    localparam logic [2:0] ALU_ADD = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;
    localparam logic [2:0] ALU_AND = 3'd7;

    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_SUB  = 4'd1;
    localparam logic [3:0] CMD_OR   = 4'd2;
    localparam logic [3:0] CMD_XOR  = 4'd3;
    localparam logic [3:0] CMD_AND  = 4'd4;
    localparam logic [3:0] CMD_ANDN = 4'd5;
    localparam logic [3:0] CMD_ROL  = 4'd6;
    localparam logic [3:0] CMD_SLL  = 4'd7;
    localparam logic [3:0] CMD_SRA  = 4'd8;
    localparam logic [3:0] CMD_SRL  = 4'd9;
    localparam logic [3:0] CMD_ROR  = 4'd10;
    localparam logic [3:0] CMD_SEQ  = 4'd11;
    localparam logic [3:0] CMD_SLT  = 4'd12;
    localparam logic [3:0] CMD_SLE  = 4'd13;
    localparam logic [3:0] CMD_SCO  = 4'd14;
    localparam logic [3:0] CMD_RSV  = 4'd15;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_EXEC2 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // a_const16 replaces operand A with 16; b_rot replaces operand B with the captured rotate count
    typedef struct packed {
        logic [2:0] op;
        logic       inva;
        logic       invb;
        logic       cin;
        logic       sign;
        logic       a_const16;
        logic       b_rot;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_seq_ctrl_cmd_decode.sv
// Combinational command-to-ALU-control decode; pass2 selects the second pass of ROR.
module alu_cmd_decode
    import alu_seq_ctrl_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       pass2,
    output alu_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (cmd)
            CMD_ADD: begin
                ctrl.op   = ALU_ADD;
                ctrl.sign = 1'b1;
            end
            CMD_SUB, CMD_SEQ, CMD_SLT, CMD_SLE: begin
                ctrl.op   = ALU_ADD;
                ctrl.invb = 1'b1;
                ctrl.cin  = 1'b1;
                ctrl.sign = 1'b1;
            end
            CMD_OR:   ctrl.op = ALU_OR;
            CMD_XOR:  ctrl.op = ALU_XOR;
            CMD_AND:  ctrl.op = ALU_AND;
            CMD_ANDN: begin
                ctrl.op   = ALU_AND;
                ctrl.invb = 1'b1;
            end
            CMD_ROL:  ctrl.op = ALU_ROL;
            CMD_SLL:  ctrl.op = ALU_SLL;
            CMD_SRA:  ctrl.op = ALU_SRA;
            CMD_SRL:  ctrl.op = ALU_SRL;
            // rotate right = rotate left by (16 - B[3:0]) mod 16, computed on the first pass
            CMD_ROR: begin
                if (pass2) begin
                    ctrl.op    = ALU_ROL;
                    ctrl.b_rot = 1'b1;
                end else begin
                    ctrl.op        = ALU_ADD;
                    ctrl.invb      = 1'b1;
                    ctrl.cin       = 1'b1;
                    ctrl.a_const16 = 1'b1;
                end
            end
            CMD_SCO:  ctrl.op = ALU_ADD;
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for an external combinational ALU: accepts a command, runs one or
// two ALU passes from registered operands, and holds the result until consumed.
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   EXEC  | first ALU pass from registered command
//   EXEC2 | second ALU pass (ROR only)
//   DONE  | res_valid high, result held until res_ready
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_ofl,
    output logic        res_err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_inva,
    output logic        alu_invb,
    output logic        alu_cin,
    output logic        alu_sign,
    input  logic [15:0] alu_out,
    input  logic        alu_ofl,
    input  logic        alu_z
);

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  rot_q;
    alu_ctrl_t   ctrl;
    logic        exec;
    logic        slt_bit;
    logic [15:0] nxt_data;
    logic        nxt_ofl;
    logic        nxt_err;

    alu_cmd_decode u_decode (
        .cmd   (op_q),
        .pass2 (state == ST_EXEC2),
        .ctrl  (ctrl)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_DONE);
    assign exec      = (state == ST_EXEC) || (state == ST_EXEC2);

    // ALU controls are zero outside the execute states, so reset clears them immediately
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = '0;
        alu_inva = 1'b0;
        alu_invb = 1'b0;
        alu_cin  = 1'b0;
        alu_sign = 1'b0;
        if (exec) begin
            alu_a    = ctrl.a_const16 ? 16'd16 : a_q;
            alu_b    = ctrl.b_rot ? {12'd0, rot_q} : b_q;
            alu_op   = ctrl.op;
            alu_inva = ctrl.inva;
            alu_invb = ctrl.invb;
            alu_cin  = ctrl.cin;
            alu_sign = ctrl.sign;
        end
    end

    always_comb begin
        slt_bit  = alu_out[15] ^ alu_ofl;
        nxt_data = alu_out;
        nxt_ofl  = 1'b0;
        nxt_err  = 1'b0;
        case (op_q)
            CMD_ADD, CMD_SUB: nxt_ofl  = alu_ofl;
            CMD_SEQ:          nxt_data = {15'd0, alu_z};
            CMD_SLT:          nxt_data = {15'd0, slt_bit};
            CMD_SLE:          nxt_data = {15'd0, slt_bit | alu_z};
            CMD_SCO:          nxt_data = {15'd0, alu_ofl};
            CMD_RSV: begin
                nxt_data = '0;
                nxt_err  = 1'b1;
            end
            default:          nxt_data = alu_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rot_q    <= '0;
            res_data <= '0;
            res_ofl  <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == CMD_ROR) begin
                        rot_q <= alu_out[3:0];
                        state <= ST_EXEC2;
                    end else begin
                        res_data <= nxt_data;
                        res_ofl  <= nxt_ofl;
                        res_err  <= nxt_err;
                        state    <= ST_DONE;
                    end
                end
                ST_EXEC2: begin
                    res_data <= nxt_data;
                    res_ofl  <= nxt_ofl;
                    res_err  <= nxt_err;
                    state    <= ST_DONE;
                end
                default: begin
                    if (res_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have ports, in order: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have cmd_valid in 1 (command offered), cmd_ready out 1 (command accepted when both high at a clk rising edge).
REQ-003 SHALL have cmd_op in 4 (command code per REQ-012), cmd_a in 16 (operand A), cmd_b in 16 (operand B).
REQ-004 SHALL have res_valid out 1, res_ready in 1, res_data out 16, res_ofl out 1 (signed overflow), res_err out 1 (reserved command).
REQ-005 SHALL drive the external ALU: alu_a out 16, alu_b out 16, alu_op out 3, alu_inva out 1, alu_invb out 1, alu_cin out 1, alu_sign out 1.
REQ-006 SHALL receive the combinational ALU result in the same cycle: alu_out in 16, alu_ofl in 1, alu_z in 1.
REQ-007 SHALL use ALU op encoding: 0 rotate-left, 1 sll, 2 sra, 3 srl, 4 add, 5 or, 6 xor, 7 and; ALU computes inA+inB+cin, where inA/inB are the optionally inverted operands; shift count is inB[3:0].

Function
REQ-008 SHALL implement FSM states IDLE, EXEC, EXEC2, DONE.
REQ-009 SHALL assert cmd_ready only in IDLE; on acceptance, SHALL register cmd_op, cmd_a, cmd_b and go to EXEC.
REQ-010 SHALL, in EXEC/EXEC2, drive ALU controls from registered values only, capture ALU outputs at the end of that cycle, then go to DONE (or EXEC2 for ROR).
REQ-011 SHALL assert res_valid only in DONE with stable res_* until res_ready, then return to IDLE; no new command accepted in the DONE cycle.
REQ-012 SHALL map commands: 0 ADD (op4, sign1); 1 SUB A-B (op4, invb1, cin1, sign1); 2 OR; 3 XOR; 4 AND; 5 ANDN A&~B (op7, invb1); 6 ROL; 7 SLL; 8 SRA; 9 SRL; 10 ROR; 11 SEQ; 12 SLT; 13 SLE; 14 SCO; 15 reserved.
REQ-013 SHALL drive cin=0, inva=0 and invb=0 for every command except those stated otherwise.
REQ-014 SHALL set res_ofl = alu_ofl for ADD/SUB, 0 for all others.
REQ-015 SEQ/SLT/SLE SHALL execute SUB A-B signed; result bit: SEQ = alu_z; SLT = alu_out[15]^alu_ofl; SLE = SLT|alu_z; res_data = zero-extended bit.
REQ-016 SCO SHALL execute add with sign=0; res_data = {15'b0, alu_ofl} (unsigned carry out).
REQ-017 ROR SHALL use two passes: EXEC computes 16-B[3:0] (alu_a=16, alu_b=B, SUB); EXEC2 rotates A left by captured alu_out[3:0]; B[3:0]=0 yields A unchanged.
REQ-018 Latency: res_valid SHALL rise 2 clk edges after acceptance (3 for ROR), with res_ready held high.
REQ-019 cmd_op 15 SHALL complete in 2 cycles with res_err=1, res_data=0, res_ofl=0; res_err=0 for all others.
REQ-020 cmd_valid/cmd_* changes while not in IDLE SHALL have no effect.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, res_valid=0, res_data=0, res_ofl=0, res_err=0, all alu_* outputs 0, regardless of clk.
REQ-022 Reset mid-operation (EXEC, EXEC2, DONE) SHALL discard the in-flight command; cmd_ready=1 on the first edge after release.

Structure
REQ-023 Shared package SHALL hold ALU op codes (3-bit), command codes (4-bit), FSM state encoding.
REQ-024 Command-to-ALU-control decode SHALL be one combinational sub-module alu_cmd_decode; ALU itself SHALL stay external.

Verification
REQ-025 ADD A=0x7FFF B=0x0001 -> res_data 0x8000, res_ofl 1, res_valid 2 cycles after accept.
REQ-026 SLT A=0x8000 B=0x0001 -> res_data 0x0001; SLE A=B=0x1234 -> 0x0001; SEQ A=0x1234 B=0x1235 -> 0x0000.
REQ-027 ROR A=0x8001 B=0x0004 -> res_data 0x1800 after 3 cycles; B=0x0000 -> 0x8001.
REQ-028 SCO A=0xFFFF B=0x0001 -> res_data 0x0001, res_ofl 0; cmd_op 15 -> res_err 1, res_data 0.
REQ-029 res_ready held low 5 cycles in DONE -> res_* stable, cmd_ready 0 throughout; then accept next command.
REQ-030 rst_n pulsed low during EXEC2 of ROR -> res_valid never asserts for it, all outputs 0 asynchronously.
